// File: rtl/encrypt_pkg.sv
// Shared constants for the encrypt/decrypt pair: XOR keys, bit permutation
// table, default output buffer depth, and the inverse-permutation helper.
`timescale 1ns/1ps
package encrypt_pkg;

  localparam logic [7:0]  XOR_KEY1 = 8'hA5;
  localparam logic [7:0]  XOR_KEY2 = 8'h3C;
  localparam logic [7:0]  XOR_KEY3 = 8'h96;
  localparam logic [23:0] KEY_INIT = {XOR_KEY1, XOR_KEY2, XOR_KEY3};

  // Encryptor moves plain bit PERM[i] to cipher bit i (before the XOR).
  localparam logic [2:0] PERM [8] = '{3'd3, 3'd6, 3'd0, 3'd5, 3'd7, 3'd1, 3'd4, 3'd2};

  localparam int FIFO_DEPTH_DEF = 4;

  // Rotate so the next key in the KEY3, KEY1, KEY2 cycle lands in bits [7:0].
  function automatic logic [23:0] key_rot(input logic [23:0] k);
    return {k[15:8], k[7:0], k[23:16]};
  endfunction

  // Undo the encryptor's bit shuffle: plain[PERM[i]] = x[i].
  function automatic logic [7:0] inv_perm(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h00;
    p[PERM[0]] = x[0];
    p[PERM[1]] = x[1];
    p[PERM[2]] = x[2];
    p[PERM[3]] = x[3];
    p[PERM[4]] = x[4];
    p[PERM[5]] = x[5];
    p[PERM[6]] = x[6];
    p[PERM[7]] = x[7];
    return p;
  endfunction

endpackage

// File: rtl/decrypt_fifo.sv
// Show-ahead byte FIFO for decrypted output. A push into a full FIFO is
// accepted only when a pop happens on the same edge; otherwise it is dropped.
`timescale 1ns/1ps
module decrypt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage array; contents are don't-care while empty since o_data is gated.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/decrypt_unit.sv
// Two-stage XOR/permutation decryptor with rotating key and output FIFO.
// Stage 1 registers the ciphertext and its key; stage 2 decrypts
// combinationally and pushes into the show-ahead FIFO on the next edge.
`timescale 1ns/1ps
module decrypt_unit
  import encrypt_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          v_in,
  input  logic                          resync,
  output logic [7:0]                    dout,
  output logic                          v,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  input  logic                          clr_ovf
);

  logic [23:0] r_key;
  logic [7:0]  r_s1_din;
  logic [7:0]  r_s1_key;
  logic        r_s1_v;
  logic        r_ovf;
  logic [7:0]  w_key_act;
  logic [7:0]  w_plain;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf_set;

  // A resync byte must already see KEY3, so bypass the stale register.
  assign w_key_act = resync ? KEY_INIT[7:0] : r_key[7:0];
  assign w_plain   = inv_perm(r_s1_din ^ r_s1_key);

  // Full implies non-empty, so a pop is exactly 'ready' whenever full.
  assign w_ovf_set = r_s1_v & w_full & ~ready;

  // Key register: resync reloads (and advances if a byte is consumed now).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key <= KEY_INIT;
    end else if (resync) begin
      r_key <= v_in ? key_rot(KEY_INIT) : KEY_INIT;
    end else if (v_in) begin
      r_key <= key_rot(r_key);
    end
  end

  // Stage 1 capture; holds its data when no byte arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_din <= 8'h00;
      r_s1_key <= 8'h00;
      r_s1_v   <= 1'b0;
    end else begin
      r_s1_v <= v_in;
      if (v_in) begin
        r_s1_din <= din;
        r_s1_key <= w_key_act;
      end
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
  assign v   = ~w_empty;

  decrypt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s1_v),
    .i_data  (w_plain),
    .i_pop   (ready),
    .o_data  (dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

endmodule

// File: doc/decrypt_unit.md
DECRYPT_UNIT -- requirements
Module: decrypt_unit

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in bytes (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, 8, ciphertext byte from the encrypt_unit output.
REQ-005 The block SHALL have port v_in, input, 1, din valid; no backpressure toward the source.
REQ-006 The block SHALL have port resync, input, 1, single-cycle pulse that realigns the key phase.
REQ-007 The block SHALL have port dout, output, 8, plaintext byte at FIFO head.
REQ-008 The block SHALL have port v, output, 1, dout valid (FIFO not empty).
REQ-009 The block SHALL have port ready, input, 1, downstream accept; a byte is popped when v and ready are both 1.
REQ-010 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-011 The block SHALL have port ovf, output, 1, sticky overflow flag.
REQ-012 The block SHALL have port clr_ovf, input, 1, clears ovf.

Function
REQ-013 The block SHALL hold a 24-bit key register, initialised to {XOR_KEY1, XOR_KEY2, XOR_KEY3}, and use bits [7:0] as the active key.
REQ-014 On each cycle with v_in=1, stage 1 SHALL capture din and the active key, then rotate the key register to {k[15:8], k[7:0], k[23:16]}; the active-key sequence is therefore KEY3, KEY1, KEY2, KEY3, ...
REQ-015 With v_in=0 the key register and stage 1 SHALL hold.
REQ-016 Stage 2 SHALL compute x = din_ff ^ key_ff, then plain[PERM_i] = x[i] for i = 0..7 (inverse bit permutation), and push plain into the FIFO on the edge after capture.
REQ-017 Latency SHALL be 2 clocks: a byte presented with v_in at edge N appears on dout with v=1 after edge N+1 when the FIFO was empty (show-ahead FIFO).
REQ-018 The first byte after reset SHALL be decrypted like any other; the encryptor's pipeline-fill byte decrypts to 8'h00 and is passed through.
REQ-019 resync=1 SHALL reload the key register to its reset value at the next edge; if v_in=1 in the same cycle, that byte SHALL use KEY3 and the register SHALL load the rotated reset value.
REQ-020 Push when the FIFO is full with no pop in the same cycle SHALL drop the byte, leave FIFO contents unchanged, and set ovf.
REQ-021 Push and pop in the same cycle SHALL be accepted at any level, including full; level SHALL be unchanged.
REQ-022 Pop when empty SHALL be ignored; dout SHALL be 8'h00 whenever v=0.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-024 clr_ovf SHALL clear ovf; if an overflow occurs in the same cycle, ovf SHALL remain 1 (set wins).

Reset
REQ-025 rst=0 SHALL asynchronously clear stage 1, the pipeline valids, the FIFO pointers, level, v, dout and ovf, and load the key register with {XOR_KEY1, XOR_KEY2, XOR_KEY3}.
REQ-026 Reset in mid-stream SHALL discard all buffered and in-flight bytes; no partial byte SHALL appear after reset release.

Structure
REQ-027 A shared package encrypt_pkg SHALL hold XOR_KEY1=8'hA5, XOR_KEY2=8'h3C, XOR_KEY3=8'h96, the permutation table PERM[0:7]={3,6,0,5,7,1,4,2}, and the default FIFO_DEPTH; encrypt_unit and decrypt_unit SHALL share these values.
REQ-028 The output buffer SHALL be a sub-module, decrypt_fifo, with push/pop/full/empty/level ports; key rotation and stage 1/stage 2 SHALL reside in decrypt_unit.

Verification
REQ-029 After reset, v_in=1 with din 96, A5, 3C, ready=1 -> dout 00, 00, 00 on consecutive cycles, starting 2 clocks after the first byte.
REQ-030 Loopback: encrypt_unit feeding decrypt_unit with 64 random bytes, ready=1 -> the output equals 00 followed by the input sequence; ovf=0.
REQ-031 ready=0 with 5 bytes pushed at FIFO_DEPTH=4 -> level=4, ovf=1, and the first 4 bytes are retained in order; clr_ovf pulse -> ovf=0.
REQ-032 At full with ready=1 and v_in=1 in the same cycle -> level stays 4, ovf stays 0, and FIFO order is preserved.
REQ-033 After 2 bytes, resync with din=69 -> dout FF (key KEY3); the next byte uses KEY1.
REQ-034 rst asserted with 3 bytes buffered and 1 in flight -> v=0, level=0, dout=00 immediately; the next byte uses KEY3.
